wb_stage: RTL and testbench

//   Write-back stage, directly upstream of the register file write port. Accepts retired

---
 rtl/wb_stage_if.sv | 48 ++++
 rtl/wb_stage.sv | 192 +++++++++++++++++++
 tb/tb_wb_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : Bundle of the MEM->WB handshake, the data-memory load
//               response and the regfile write port seen by wb_stage.
//               master : the environment (MEM stage, dmem, regfile observer)
//               slave  : wb_stage itself
//   in_valid/in_ready          accept handshake from MEM
//   in_wreg/in_waddr/in_wdata  destination register info and ALU result
//   in_is_load/in_ld_funct3/in_addr_lo  load descriptor
//   dmem_rvalid/dmem_rdata     single-cycle load response
//   we/waddr/wdata             registered regfile write port
//   align_err/ld_timeout       sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wreg;
    logic [REG_AW-1:0] in_waddr;
    logic [XLEN-1:0]   in_wdata;
    logic              in_is_load;
    logic [2:0]        in_ld_funct3;
    logic [1:0]        in_addr_lo;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic              align_err;
    logic              ld_timeout;

    modport master (
        output in_valid, in_wreg, in_waddr, in_wdata, in_is_load,
               in_ld_funct3, in_addr_lo, dmem_rvalid, dmem_rdata,
        input  in_ready, we, waddr, wdata, align_err, ld_timeout
    );

    modport slave (
        input  in_valid, in_wreg, in_waddr, in_wdata, in_is_load,
               in_ld_funct3, in_addr_lo, dmem_rvalid, dmem_rdata,
        output in_ready, we, waddr, wdata, align_err, ld_timeout
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage. Accepts retiring instructions from MEM,
//               waits for data-memory load responses, formats load data
//               (byte/half select, sign/zero extension) and drives the
//               regfile write port as a registered one-cycle pulse.
//               MEM is back-pressured while a load is outstanding.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active-low
//               bus  - wb_stage_if.slave (handshake, dmem response,
//                      regfile write port, sticky error flags)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int LD_TIMEOUT = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_stage_if.slave   bus
);

    // Wait counter is 8 bits wide, enough for LD_TIMEOUT up to 255.
    // The timeout fires in the LD_TIMEOUT-th wait cycle, i.e. while the
    // counter still shows LD_TIMEOUT-1.
    localparam logic [7:0] c_CNT_LAST = 8'(LD_TIMEOUT - 1);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_align_err;
    logic              r_ld_timeout;
    logic [7:0]        r_cnt;

    // Descriptor of the outstanding load, captured at accept.
    logic              r_ld_wreg;
    logic [REG_AW-1:0] r_ld_waddr;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_lo;
    logic              r_ld_legal;

    state_t            w_state_nxt;
    logic              w_we_nxt;
    logic [REG_AW-1:0] w_waddr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;
    logic [7:0]        w_cnt_nxt;
    logic              w_set_align;
    logic              w_set_to;
    logic              w_ld_capture;
    logic              w_in_legal;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_ld_fmt;

    // Legality of the load currently presented by MEM.
    always_comb begin
        w_in_legal = 1'b0;
        case (bus.in_ld_funct3)
            c_F3_LB, c_F3_LBU: w_in_legal = 1'b1;
            c_F3_LH, c_F3_LHU: w_in_legal = ~bus.in_addr_lo[0];
            c_F3_LW:           w_in_legal = (bus.in_addr_lo == 2'b00);
            default:           w_in_legal = 1'b0;
        endcase
    end

    // Load data formatting from the captured descriptor.
    always_comb begin
        w_byte = bus.dmem_rdata[7:0];
        case (r_ld_lo)
            2'd0:    w_byte = bus.dmem_rdata[7:0];
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = r_ld_lo[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

        // Illegal funct3 falls through to the raw word; its write is
        // suppressed anyway.
        w_ld_fmt = bus.dmem_rdata;
        case (r_ld_funct3)
            c_F3_LB:  w_ld_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_LBU: w_ld_fmt = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_LH:  w_ld_fmt = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_LHU: w_ld_fmt = {{(XLEN-16){1'b0}}, w_half};
            default:  w_ld_fmt = bus.dmem_rdata;
        endcase
    end

    // Next-state and write-port logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_cnt_nxt    = r_cnt;
        w_set_align  = 1'b0;
        w_set_to     = 1'b0;
        w_ld_capture = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Stray dmem_rvalid in this state is deliberately ignored.
                if (bus.in_valid) begin
                    if (bus.in_is_load) begin
                        w_ld_capture = 1'b1;
                        w_cnt_nxt    = 8'd0;
                        w_set_align  = ~w_in_legal;
                        w_state_nxt  = S_LOAD_WAIT;
                    end else begin
                        w_we_nxt    = bus.in_wreg & (bus.in_waddr != '0);
                        w_waddr_nxt = bus.in_waddr;
                        w_wdata_nxt = bus.in_wdata;
                    end
                end
            end
            S_LOAD_WAIT: begin
                // A response in the timeout cycle takes priority.
                if (bus.dmem_rvalid) begin
                    w_state_nxt = S_IDLE;
                    w_we_nxt    = r_ld_wreg & (r_ld_waddr != '0) & r_ld_legal;
                    w_waddr_nxt = r_ld_waddr;
                    w_wdata_nxt = w_ld_fmt;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_align_err  <= 1'b0;
            r_ld_timeout <= 1'b0;
            r_cnt        <= 8'd0;
            r_ld_wreg    <= 1'b0;
            r_ld_waddr   <= '0;
            r_ld_funct3  <= 3'd0;
            r_ld_lo      <= 2'd0;
            r_ld_legal   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_set_align) begin
                r_align_err <= 1'b1;
            end
            if (w_set_to) begin
                r_ld_timeout <= 1'b1;
            end
            if (w_ld_capture) begin
                r_ld_wreg   <= bus.in_wreg;
                r_ld_waddr  <= bus.in_waddr;
                r_ld_funct3 <= bus.in_ld_funct3;
                r_ld_lo     <= bus.in_addr_lo;
                r_ld_legal  <= w_in_legal;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.we         = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;
    assign bus.align_err  = r_align_err;
    assign bus.ld_timeout = r_ld_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage. Drivers push the expected
//               regfile writes (with the cycle they must appear in) into a
//               queue; a negedge monitor pops and compares each write and
//               tracks the expected sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    localparam int c_LD_TO = 4;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    bit   exp_align = 1'b0;
    bit   exp_to    = 1'b0;
    wr_t  q[$];

    wb_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    wb_stage #(.XLEN(32), .REG_AW(5), .LD_TIMEOUT(c_LD_TO)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && lo[0]) return 1'b0;
        if (f3 == 3'd2 && lo != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (rd >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missing_write_cycle", 32'(cyc), 32'(q[0].cyc));
            void'(q.pop_front());
        end
        if (bus.we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write_we", {31'd0, bus.we}, 32'd0);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
                chk("write_waddr", {27'd0, bus.waddr}, {27'd0, e.a});
                chk("write_wdata", bus.wdata, e.d);
            end
        end
        chk("align_err", {31'd0, bus.align_err}, {31'd0, exp_align});
        chk("ld_timeout", {31'd0, bus.ld_timeout}, {31'd0, exp_to});
    end

    // ---------------- drivers ----------------
    task automatic junk_inputs();
        bus.in_wreg      = 1'($urandom);
        bus.in_waddr     = 5'($urandom);
        bus.in_wdata     = $urandom;
        bus.in_is_load   = 1'($urandom);
        bus.in_ld_funct3 = 3'($urandom);
        bus.in_addr_lo   = 2'($urandom);
    endtask

    task automatic issue_alu(input bit wreg, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("in_ready_before_alu", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_wreg    = wreg;
        bus.in_waddr   = a;
        bus.in_wdata   = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        junk_inputs();
        if (wreg && a != 5'd0) q.push_back('{cyc, a, d});
    endtask

    // delay = wait cycles without rvalid; delay >= c_LD_TO means no response.
    task automatic do_load(input bit wreg, input logic [4:0] a, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rd, input int delay);
        bit legal;
        legal = m_legal(f3, lo);
        @(negedge clk);
        chk("in_ready_before_load", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid     = 1'b1;
        bus.in_is_load   = 1'b1;
        bus.in_wreg      = wreg;
        bus.in_waddr     = a;
        bus.in_ld_funct3 = f3;
        bus.in_addr_lo   = lo;
        bus.in_wdata     = $urandom;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        junk_inputs();
        if (!legal) exp_align = 1'b1;
        for (int i = 0; i < delay && i < c_LD_TO; i++) begin
            @(negedge clk);
            chk("in_ready_load_wait", {31'd0, bus.in_ready}, 32'd0);
            // MEM may present (and must not get accepted) while waiting.
            junk_inputs();
            bus.in_valid = 1'($urandom);
        end
        if (delay < c_LD_TO) begin
            @(negedge clk);
            chk("in_ready_rvalid_cycle", {31'd0, bus.in_ready}, 32'd0);
            bus.in_valid    = 1'b0;
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rd;
            @(posedge clk);
            #1;
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = $urandom;
            if (wreg && a != 5'd0 && legal) q.push_back('{cyc, a, m_fmt(f3, lo, rd)});
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            exp_to = 1'b1;
        end
    endtask

    task automatic stray_rvalid();
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = $urandom;
        @(posedge clk);
        #1;
        bus.dmem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
        junk_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", {31'd0, bus.we}, 32'd0);
        chk("reset_waddr", {27'd0, bus.waddr}, 32'd0);
        chk("reset_wdata", bus.wdata, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write, then an idle cycle that must carry no write.
        issue_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        idle(2);

        // Back-to-back writes, then a write to x0.
        issue_alu(1'b1, 5'd1, 32'h1111_1111);
        issue_alu(1'b1, 5'd2, 32'h2222_2222);
        issue_alu(1'b1, 5'd3, 32'h3333_3333);
        issue_alu(1'b1, 5'd0, 32'h0BAD_0BAD);
        idle(2);

        // Load formatting, rvalid 3 cycles after accept.
        do_load(1'b1, 5'd10, 3'b000, 2'd0, 32'h8000_F0A5, 3);
        do_load(1'b1, 5'd11, 3'b100, 2'd1, 32'h8000_F0A5, 3);
        do_load(1'b1, 5'd12, 3'b001, 2'd2, 32'h8000_F0A5, 3);
        do_load(1'b1, 5'd13, 3'b101, 2'd2, 32'h8000_F0A5, 3);
        do_load(1'b1, 5'd14, 3'b010, 2'd0, 32'h8000_F0A5, 3);
        idle(1);

        // Misaligned LW and illegal funct3.
        do_load(1'b1, 5'd15, 3'b010, 2'd2, 32'hCAFE_F00D, 1);
        issue_alu(1'b1, 5'd16, 32'hA5A5_A5A5);
        do_load(1'b1, 5'd17, 3'b011, 2'd0, 32'hCAFE_F00D, 0);

        // Response exactly in the timeout cycle, then a real timeout.
        do_load(1'b1, 5'd18, 3'b010, 2'd0, 32'h1234_5678, c_LD_TO - 1);
        do_load(1'b1, 5'd19, 3'b010, 2'd0, 32'h1234_5678, c_LD_TO);
        idle(1);
        stray_rvalid();
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 5) begin
                issue_alu(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom);
            end else if (k < 9) begin
                logic [2:0] f3;
                f3 = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2)
                                                 : 3'($urandom);
                do_load(1'($urandom_range(0, 3) != 0), 5'($urandom), f3, 2'($urandom),
                        $urandom, $urandom_range(0, c_LD_TO));
            end else begin
                stray_rvalid();
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Asynchronous reset in the middle of a load wait.
        issue_alu(1'b1, 5'd7, 32'h1234_5678);
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.in_is_load   = 1'b1;
        bus.in_wreg      = 1'b1;
        bus.in_waddr     = 5'd9;
        bus.in_ld_funct3 = 3'b010;
        bus.in_addr_lo   = 2'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_before_async_rst", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst_n     = 1'b0;
        exp_align = 1'b0;
        exp_to    = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, bus.we}, 32'd0);
        chk("async_rst_waddr", {27'd0, bus.waddr}, 32'd0);
        chk("async_rst_wdata", bus.wdata, 32'd0);
        chk("async_rst_align_err", {31'd0, bus.align_err}, 32'd0);
        chk("async_rst_ld_timeout", {31'd0, bus.ld_timeout}, 32'd0);
        chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        q.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        stray_rvalid();
        @(negedge clk);
        chk("in_ready_after_rst_rvalid", {31'd0, bus.in_ready}, 32'd1);
        idle(3);
        chk("pending_writes", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
